// File: rtl/demux4_reg.sv
// ----------------------------------------------------------------------------
// demux4_reg
//   Registered 1-to-4 data distributor. Accepts one upstream beat (data plus a
//   2-bit destination select) over a valid/ready handshake. It holds the beat
//   in a single pipeline register and presents it on exactly one of four
//   downstream valid/ready ports. The block routes writeback/store data from
//   one producer to the regfile, data memory, CSR or MMIO consumer, and it
//   passes backpressure straight through.
//
// Optional feature (macro DEMUX4_CNT_EN):
//   When this macro is defined, the block adds the beat_cnt output. beat_cnt
//   holds four 16-bit wrapping counters of downstream handshakes, one counter
//   per port. The counter for port i sits at bits [16i+15:16i].
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream beat valid
//   in_ready   out  beat can be accepted this cycle (combinational from out_ready)
//   in_data    in   upstream data [WIDTH]
//   in_sel     in   destination port 0..3, sampled on an accepted beat
//   out_valid  out  per-port valid, one-hot or zero
//   out_ready  in   per-port ready from the consumers
//   out_data   out  held data broadcast to all ports [WIDTH]
//   beat_cnt   out  per-port handshake counters [64] (DEMUX4_CNT_EN only)
// ----------------------------------------------------------------------------
module demux4_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef DEMUX4_CNT_EN
    ,
    output logic [63:0]      beat_cnt
`endif
);

    localparam int unsigned NPORTS = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data;
    logic [SEL_W-1:0]   r_sel;

    logic               w_full;
    logic               w_sel_ready;
    logic               w_accept;
    logic               w_drain;

    // Handshake decode: the selected port's ready frees the slot in the same cycle
    assign w_full      = (r_state == ST_FULL);
    assign w_sel_ready = out_ready[r_sel];
    assign w_drain     = w_full && w_sel_ready;
    assign in_ready    = !w_full || w_sel_ready;
    assign w_accept    = in_valid && in_ready;

    // Pipeline slot: an accept takes priority, so drain+accept keeps the slot full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_sel   <= in_sel;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_data  <= in_data;
                        r_sel   <= in_sel;
                        r_state <= ST_FULL;
                    end else if (w_drain) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // Steer the held beat's valid onto its selected port only
    always_comb begin
        out_valid = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            out_valid[i] = w_full && (r_sel == SEL_W'(i));
        end
    end

    assign out_data = r_data;

`ifdef DEMUX4_CNT_EN
    localparam int unsigned CNT_W = 16;

    logic [NPORTS-1:0][CNT_W-1:0] r_cnt;

    // Per-port downstream handshake counters, wrapping naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign beat_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// ----------------------------------------------------------------------------
// tb_demux4_reg
//   Directed, self-checking bench for demux4_reg. The bench drives inputs one
//   time unit after each rising edge and samples outputs once they settle,
//   well before the next edge. Every expected value is hand-computed.
// ----------------------------------------------------------------------------
module tb_demux4_reg;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef DEMUX4_CNT_EN
    logic [63:0]      beat_cnt;
`endif

    int n_vec;
    int n_err;

    demux4_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX4_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then let the outputs settle before the caller drives or checks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;

        // Reset state
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data",  64'(out_data),  64'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'h1);

        // Single beat to port 2 with no downstream ready
        in_valid  = 1'b1;
        in_data   = 32'hDEADBEEF;
        in_sel    = 2'd2;
        out_ready = 4'b0000;
        #1;
        chk("single_in_ready_empty", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        in_sel   = 2'd0;
        #1;
        chk("single_out_valid",  64'(out_valid), 64'h4);
        chk("single_out_data",   64'(out_data),  64'hDEADBEEF);
        chk("single_in_ready",   64'(in_ready),  64'h0);
        step();
        chk("single_hold_valid", 64'(out_valid), 64'h4);
        out_ready = 4'b0100;
        #1;
        chk("single_ready_pass", 64'(in_ready),  64'h1);
        step();
        out_ready = 4'b0000;
        #1;
        chk("single_drained",    64'(out_valid), 64'h0);
        chk("single_data_kept",  64'(out_data),  64'hDEADBEEF);

        // Streaming to ports 0..3 back-to-back
        out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 32'hA1 + 32'(k);
            in_sel   = 2'(k);
            #1;
            chk("stream_in_ready", 64'(in_ready), 64'h1);
            step();
            chk("stream_out_valid", 64'(out_valid), 64'(4'b0001 << k));
            chk("stream_out_data",  64'(out_data),  64'(32'hA1 + 32'(k)));
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", 64'(out_valid), 64'h0);

        // Non-selected ready must not drain; stalled inputs are ignored
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 32'h12345678;
        in_sel    = 2'd1;
        step();
        in_data   = 32'hFFFFFFFF;
        in_sel    = 2'd3;
        out_ready = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("wrong_in_ready", 64'(in_ready), 64'h0);
            step();
            chk("wrong_out_valid", 64'(out_valid), 64'h2);
            chk("wrong_out_data",  64'(out_data),  64'h12345678);
        end
        in_valid  = 1'b0;
        out_ready = 4'b0010;
        #1;
        chk("wrong_sel_ready", 64'(in_ready), 64'h1);
        step();
        chk("wrong_drained", 64'(out_valid), 64'h0);

        // Simultaneous drain of port 3 and accept for port 0
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA;
        in_sel    = 2'd3;
        step();
        chk("sim_first_valid", 64'(out_valid), 64'h8);
        out_ready = 4'b1000;
        in_data   = 32'h55;
        in_sel    = 2'd0;
        #1;
        chk("sim_in_ready", 64'(in_ready), 64'h1);
        step();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #1;
        chk("sim_out_valid", 64'(out_valid), 64'h1);
        chk("sim_out_data",  64'(out_data),  64'h55);

        // Reset while a beat is held, asserted mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'h0);
        chk("midrst_out_data",  64'(out_data),  64'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready",  64'(in_ready),  64'h1);
        step();
        chk("midrst_stay_empty", 64'(out_valid), 64'h0);

`ifdef DEMUX4_CNT_EN
        // 65537 handshakes on port 0: counter 0 wraps to 1, others stay 0
        chk("cnt_after_reset", beat_cnt, 64'h0);
        out_ready = 4'b0001;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        for (int k = 0; k < 65537; k++) begin
            in_data = 32'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        out_ready = 4'b0000;
        #1;
        chk("cnt_wrap", beat_cnt, 64'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
